// File: rtl/limn2600_uart_pkg.sv
// Shared definitions for the Limn2600 transmit UART: register offsets, STATUS/CTRL
// bit positions and the bus/TX state encodings.
package limn2600_uart_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_BUSY      = 2;
  localparam int unsigned ST_PENDING   = 3;
  localparam int unsigned ST_OVERFLOW  = 4;
  localparam int unsigned ST_COUNT_LSB = 8;

  localparam int unsigned CTRL_IRQ_EN    = 0;
  localparam int unsigned CTRL_CLR_PEND  = 1;
  localparam int unsigned CTRL_CLR_OVF   = 2;

  localparam logic [0:0] BIDLE = 1'b0;
  localparam logic [0:0] BACK  = 1'b1;

  localparam logic [1:0] TIDLE  = 2'd0;
  localparam logic [1:0] TSTART = 2'd1;
  localparam logic [1:0] TDATA  = 2'd2;
  localparam logic [1:0] TSTOP  = 2'd3;

  // A divisor of zero behaves as one clock per bit.
  function automatic logic [15:0] bit_len(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/limn2600_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push while full is accepted only
// when a pop frees a slot on the same edge, otherwise it is reported as a drop.
module limn2600_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && !do_push;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/limn2600_uart.sv
// Limn2600 bus-slave serial transmitter: CPU-written bytes are queued and sent 8N1 on txd.
// Optional LIMN2600_UART_TRACE_EN adds simulation-only trace messages.
module limn2600_uart
  import limn2600_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        rdy,
  output logic        irq,
  output logic        txd
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [0:0]  bstate;
  logic [31:0] rdata;
  logic        irq_en;
  logic        pending;
  logic        overflow;
  logic [15:0] divisor;
  logic [1:0]  tstate;
  logic [7:0]  shreg;
  logic [2:0]  bitcnt;
  logic [15:0] tcnt;
  logic [15:0] reload;

  logic        access;
  logic        wr;
  logic [1:0]  sel;
  logic        ctrl_wr;
  logic        tick;
  logic        tx_load;
  logic        set_pend;
  logic        clr_pend;
  logic        clr_ovf;
  logic        pending_nxt;
  logic        irq_en_nxt;
  logic [31:0] status;
  logic [31:0] rd_mux;

  logic        fifo_push;
  logic [7:0]  fifo_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic        fifo_drop;

  logic        unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], data_in[31:16]};

  assign access    = (bstate == BIDLE) && cs;
  assign wr        = access && we;
  assign sel       = addr[3:2];
  assign ctrl_wr   = wr && (sel == REG_CTRL);
  assign fifo_push = wr && (sel == REG_DATA);
  assign tick      = (tcnt == 16'd0);
  assign reload    = bit_len(divisor) - 16'd1;
  // A stop bit ending with bytes queued reloads directly, so frames abut with no idle bit.
  assign tx_load   = !fifo_empty && ((tstate == TIDLE) || ((tstate == TSTOP) && tick));
  assign set_pend  = (tstate == TSTOP) && tick && fifo_empty;
  assign clr_pend  = ctrl_wr && data_in[CTRL_CLR_PEND];
  assign clr_ovf   = ctrl_wr && data_in[CTRL_CLR_OVF];
  assign pending_nxt = set_pend | (pending & ~clr_pend);
  assign irq_en_nxt  = ctrl_wr ? data_in[CTRL_IRQ_EN] : irq_en;

  limn2600_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(data_in[7:0]),
    .pop      (tx_load),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .drop     (fifo_drop)
  );

  always_comb begin
    status                = '0;
    status[ST_EMPTY]      = fifo_empty;
    status[ST_FULL]       = fifo_full;
    status[ST_BUSY]       = (tstate != TIDLE);
    status[ST_PENDING]    = pending;
    status[ST_OVERFLOW]   = overflow;
    status[ST_COUNT_LSB +: 8] = 8'(fifo_count);
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_STATUS:  rd_mux = status;
      REG_CTRL:    rd_mux[CTRL_IRQ_EN] = irq_en;
      REG_DIVISOR: rd_mux[15:0] = divisor;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bstate <= BIDLE;
      rdata  <= '0;
    end else if (access) begin
      bstate <= BACK;
      rdata  <= we ? '0 : rd_mux;
    end else begin
      bstate <= BIDLE;
      rdata  <= '0;
    end
  end

  assign rdy      = (bstate == BACK);
  assign data_out = rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en   <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
      divisor  <= DIV_RESET;
      irq      <= 1'b0;
    end else begin
      irq_en   <= irq_en_nxt;
      pending  <= pending_nxt;
      overflow <= fifo_drop | (overflow & ~clr_ovf);
      irq      <= pending_nxt & irq_en_nxt;
      if (wr && (sel == REG_DIVISOR)) divisor <= data_in[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tstate <= TIDLE;
      shreg  <= '0;
      bitcnt <= '0;
      tcnt   <= '0;
    end else if (tx_load) begin
      tstate <= TSTART;
      shreg  <= fifo_data;
      bitcnt <= '0;
      tcnt   <= reload;
    end else begin
      case (tstate)
        TSTART: begin
          if (tick) begin
            tstate <= TDATA;
            tcnt   <= reload;
          end else begin
            tcnt <= tcnt - 16'd1;
          end
        end
        TDATA: begin
          if (tick) begin
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + 3'd1;
            tcnt   <= reload;
            if (bitcnt == 3'd7) tstate <= TSTOP;
          end else begin
            tcnt <= tcnt - 16'd1;
          end
        end
        TSTOP: begin
          if (tick) tstate <= TIDLE;
          else      tcnt   <= tcnt - 16'd1;
        end
        default: tstate <= TIDLE;
      endcase
    end
  end

  always_comb begin
    case (tstate)
      TSTART:  txd = 1'b0;
      TDATA:   txd = shreg[0];
      default: txd = 1'b1;
    endcase
  end

`ifdef LIMN2600_UART_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && tx_load)   $display("uart: tx %02h", fifo_data);
    if (!rst && fifo_drop) $display("uart: overflow drop %02h", data_in[7:0]);
  end
`else
`endif

endmodule

// File: tb/tb_limn2600_uart.sv
// Directed bench for limn2600_uart with a queue-based line/register model checked every cycle.
module tb_limn2600_uart;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        rdy;
  logic        irq;
  logic        txd;

  always #5 clk = ~clk;

  limn2600_uart #(
    .FIFO_DEPTH(DEPTH),
    .DIV_RESET (16'd868)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .rdy     (rdy),
    .irq     (irq),
    .txd     (txd)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes waiting in the FIFO, and the txd level for each future clock cycle.
  bit [7:0]    mq[$];
  bit          wave[$];
  logic [15:0] m_div;
  bit          m_en, m_pend, m_ovf, m_rdy, m_irq;
  logic [31:0] m_rd;
  bit          started = 0;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = (mq.size() == 0);
    s[1] = (mq.size() == DEPTH);
    s[2] = (wave.size() != 0);
    s[3] = m_pend;
    s[4] = m_ovf;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete(); wave.delete();
        m_div = 16'd868; m_en = 0; m_pend = 0; m_ovf = 0;
        m_rdy = 0; m_irq = 0; m_rd = '0;
        started = 1;
      end else begin
        bit acc, set_p, clr_p;
        logic [31:0] nrd;
        int eff;
        bit [7:0] b;
        acc = cs && !m_rdy;
        nrd = '0;
        set_p = 0; clr_p = 0;
        if (acc && !we) begin
          case (addr[3:2])
            2'd1: nrd = m_status();
            2'd2: nrd = {31'd0, m_en};
            2'd3: nrd = {16'd0, m_div};
            default: nrd = '0;
          endcase
        end
        if (wave.size() > 0) begin
          void'(wave.pop_front());
          if (wave.size() == 0 && mq.size() == 0) set_p = 1;
        end
        if (wave.size() == 0 && mq.size() > 0) begin
          b = mq.pop_front();
          eff = (m_div == 0) ? 1 : int'(m_div);
          for (int k = 0; k < 10; k++) begin
            bit lvl;
            lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            repeat (eff) wave.push_back(lvl);
          end
        end
        if (acc && we) begin
          case (addr[3:2])
            2'd0: if (mq.size() < DEPTH) mq.push_back(data_in[7:0]); else m_ovf = 1;
            2'd2: begin
              m_en = data_in[0];
              clr_p = data_in[1];
              if (data_in[2]) m_ovf = 0;
            end
            2'd3: m_div = data_in[15:0];
            default: ;
          endcase
        end
        m_pend = set_p | (m_pend & !clr_p);
        m_irq  = m_pend & m_en;
        m_rdy  = acc;
        m_rd   = nrd;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("txd", txd, (wave.size() > 0) ? wave[0] : 1'b1);
        chk("rdy", rdy, m_rdy);
        chk("data_out", data_out, m_rdy ? m_rd : 32'd0);
        chk("irq", irq, m_irq);
      end
    end
  end

  task automatic bus(input bit w, input logic [1:0] r, input logic [31:0] d, output logic [31:0] q);
    @(posedge clk); #1;
    cs = 1'b1; we = w; addr = {28'd0, r, 2'b00}; data_in = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
    @(negedge clk);
    q = data_out;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then records n txd samples, first sample in the MSB.
  task automatic capture(input int n, output logic [63:0] v);
    int guard;
    guard = 0;
    while (txd !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("frame_start_seen", txd, 1'b0);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = (v << 1) | {63'd0, txd};
      if (i < n - 1) @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [63:0] v;
    realtime t0;
    int guard, pulses;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_txd", txd, 1'b1);
    chk("reset_irq", irq, 1'b0);
    chk("reset_rdy", rdy, 1'b0);
    bus(0, 2'd1, 32'd0, r);
    chk("reset_status", r, 32'h0000_0001);

    // Single A5 frame at four clocks per bit.
    bus(1, 2'd3, 32'd4, r);
    bus(1, 2'd0, 32'h0000_00A5, r);
    capture(40, v);
    chk("a5_waveform", v, 64'h0F0F00F0FF);
    bus(0, 2'd1, 32'd0, r);
    chk("a5_done_status", r, 32'h0000_0009);

    // Three back-to-back frames, interrupt on final drain.
    bus(1, 2'd2, 32'h3, r);
    bus(1, 2'd3, 32'd2, r);
    bus(1, 2'd0, 32'h11, r);
    t0 = $realtime;
    bus(1, 2'd0, 32'h22, r);
    bus(1, 2'd0, 32'h33, r);
    guard = 0;
    while (irq !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk("irq_latency_cycles", int'(($realtime - t0) / 10.0), 61);
    bus(1, 2'd2, 32'h3, r);
    chk("irq_cleared", irq, 1'b0);

    // Overflow: 20 writes against a slow line.
    bus(1, 2'd2, 32'h6, r);
    bus(1, 2'd3, 32'd1000, r);
    for (int i = 0; i < 20; i++) bus(1, 2'd0, 32'(i + 8'h40), r);
    bus(0, 2'd1, 32'd0, r);
    chk("overflow_status", r, 32'h0000_1016);
    bus(1, 2'd2, 32'h4, r);
    bus(0, 2'd1, 32'd0, r);
    chk("overflow_cleared", r, 32'h0000_1006);
    do_reset();

    // cs held high for six edges on a DATA write.
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b1; addr = 32'h0; data_in = 32'h3C;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy) pulses++;
    end
    @(posedge clk); #1 cs = 1'b0; we = 1'b0;
    @(negedge clk);
    if (rdy) pulses++;
    chk("hold_rdy_pulses", pulses, 3);
    bus(0, 2'd1, 32'd0, r);
    chk("hold_status", r, 32'h0000_0204);
    do_reset();

    // DIVISOR=0 runs at one clock per bit.
    bus(1, 2'd3, 32'd0, r);
    bus(1, 2'd0, 32'h5A, r);
    capture(10, v);
    chk("div0_waveform", v, 64'h0B5);

    // Reset in the middle of a frame.
    bus(1, 2'd3, 32'd4, r);
    bus(1, 2'd2, 32'h1, r);
    bus(1, 2'd0, 32'hFF, r);
    capture(1, v);
    repeat (6) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midframe_reset_txd", txd, 1'b1);
    chk("midframe_reset_irq", irq, 1'b0);
    bus(0, 2'd1, 32'd0, r);
    chk("midframe_reset_status", r, 32'h0000_0001);
    bus(0, 2'd3, 32'd0, r);
    chk("midframe_reset_divisor", r, 32'd868);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
